i2s_sample_fifo: RTL and testbench
==================================

# i2s_sample_fifo

Sample buffer feeding the I2S playback transmitter. Accepts BPS-bit audio words from the sample producer over a valid/ready write port and stores them in a DEPTH-entry FIFO. Presents one word at a time on `out_sample` and drives `out_en`, which connect to the transmitter's `sample` and `in_en` inputs. Prefills before starting playback, pops on each transmitter sample request, and flags underruns.

## Interface
- BPS, 24: sample width in bits; must equal the transmitter's BPS.
- DEPTH_LOG2, 4: FIFO depth = 2^DEPTH_LOG2 words (16).
- START_LEVEL, 4: fill level required before `out_en` asserts; range 1..2^DEPTH_LOG2.

- in_clk  input  1  system clock (73.728 MHz, same domain as transmitter).
- in_rst  input  1  asynchronous, active-high reset.
- in_wr_data  input  BPS  sample word from producer.
- in_wr_valid  input  1  write request.
- out_wr_ready  output  1  FIFO not full; write accepted when valid && ready.
- in_i2s_ready  input  1  transmitter `out_ready`; a rising edge is a request for the next sample.
- out_sample  output  BPS  word offered to transmitter.
- out_en  output  1  playback enable to transmitter `in_en`.
- out_level  output  DEPTH_LOG2+1  stored word count, 0..2^DEPTH_LOG2; excludes `out_sample`.
- out_underrun  output  1  sticky underrun flag.
- in_clr_underrun  input  1  clears `out_underrun`.
- out_underrun_cnt  output  16  underrun count (see Configuration).

## Operation
- Storage: circular RAM with rd/wr pointers of DEPTH_LOG2 bits that wrap naturally, plus a level counter.
- Write: `out_wr_ready` = (level != 2^DEPTH_LOG2), combinational from registered level. Writes while full are dropped.
- Request detect: `ready_d` register, reset value 1. Request = in_i2s_ready && !ready_d. A ready held high counts once. The transmitter's idle-high ready never produces a request.
- States:
  - FILL (reset state):
    - out_en=0, out_sample=0; requests ignored.
    - When level >= START_LEVEL: pop head into out_sample, set out_en=1, go to RUN.
  - RUN:
    - On a request with level > 0: pop head into out_sample; out_en stays 1.
    - On a request with level == 0 (underrun):
      - out_sample<=0, out_en<=0, out_underrun<=1, counter increments; go to FILL.
      - The in-flight transmitter request loads 0, i.e. silence.
      - The transmitter's next request check sees out_en=0 and it returns to idle.
- Simultaneous write and pop: level unchanged; both pointers advance.
- Write in the same cycle as an underrun request: still an underrun. No bypass; the written word lands in the FIFO.
- in_clr_underrun and a new underrun in the same cycle: set wins.
- Pointers never need a flush: the FIFO content survives a FILL→RUN cycle.

## Timing
- Reset values:
  - out_sample=0, out_en=0, out_level=0, out_wr_ready=1, out_underrun=0, out_underrun_cnt=0.
  - State FILL, ready_d=1, pointers 0.
- Write accepted at edge t: out_level reflects it after edge t; the word is poppable from cycle t+1.
- Start: level >= START_LEVEL sampled at edge t. At edge t+1, out_sample and out_en update together and level decrements. The transmitter captures out_sample the same cycle it sees out_en.
- Pop latency: request seen at edge t; out_sample valid after edge t+1. This is well inside the transmitter's 5-cycle ask-to-load window. out_sample then holds stable until the next request.
- Asynchronous reset mid-RUN: all outputs return to reset values immediately, stored words are discarded, state is FILL.

## Configuration
- I2S_FIFO_UNDERRUN_CNT_EN defined:
  - out_underrun_cnt is a 16-bit counter, +1 per underrun, saturating at 0xFFFF.
  - Cleared only by in_rst; in_clr_underrun does not affect it.
- Not defined: out_underrun_cnt tied to 0; no counter logic. The sticky flag is unaffected.

## Test plan
- Reset: assert in_rst mid-RUN with level 7 → outputs return to reset values immediately; out_en=0, out_level=0.
- Prefill: write 0x000001..0x000004 → one cycle after level hits 4: out_en=1, out_sample=0x000001, out_level=3.
- Request: raise in_i2s_ready and hold 10 cycles → exactly one pop; out_sample=0x000002 on the second edge after rise; out_level=2.
- Full: write 16 words with no requests → out_level=16, out_wr_ready=0; a 17th valid write is dropped. A request then pops the oldest word and out_wr_ready returns to 1.
- Concurrency: write and request in the same cycle at level 5 → out_level stays 5, out_sample advances.
- Underrun: request at level 0 → next cycle out_sample=0, out_en=0, out_underrun=1, out_underrun_cnt=1 (0 without the macro). in_clr_underrun clears the flag.
- Recovery: after the underrun, refill 4 words → out_en reasserts.

Source files
------------

// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo: sample buffer between the audio producer and the I2S
// playback transmitter. Buffers BPS-bit words in a 2^DEPTH_LOG2-entry FIFO,
// prefills to START_LEVEL before enabling playback, pops one word for each
// rising edge of the transmitter's ready, and flags underruns.
// Optional feature: define I2S_FIFO_UNDERRUN_CNT_EN to build the saturating
// 16-bit underrun counter; otherwise out_underrun_cnt is tied to zero.

module i2s_sample_fifo #(
    parameter int BPS         = 24,
    parameter int DEPTH_LOG2  = 4,
    parameter int START_LEVEL = 4
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic [BPS-1:0]        in_wr_data,
    input  logic                  in_wr_valid,
    output logic                  out_wr_ready,
    input  logic                  in_i2s_ready,
    output logic [BPS-1:0]        out_sample,
    output logic                  out_en,
    output logic [DEPTH_LOG2:0]   out_level,
    output logic                  out_underrun,
    input  logic                  in_clr_underrun,
    output logic [15:0]           out_underrun_cnt
);

    localparam int                DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] START_LVL  = (DEPTH_LOG2 + 1)'(START_LEVEL);

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [BPS-1:0]        sample_q, sample_d;
    logic                  en_q, en_d;
    logic                  underrun_q, underrun_d;
    logic                  prev_ready_q, prev_ready_d;
    logic                  req_q, req_d;

    logic [BPS-1:0]        mem_q [DEPTH];

    logic                  wr_fire;
    logic                  pop;
    logic                  underrun_evt;

    assign out_wr_ready = (level_q != FULL_LEVEL);
    assign wr_fire      = in_wr_valid && out_wr_ready;

    // Sample storage; written at the tail on every accepted write.
    // NOTE: the RAM has no reset; the pointers and level define which entries are valid.
    always_ff @(posedge in_clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= in_wr_data;
        end
    end

    // Request detect: one pulse per rising edge of the transmitter's ready,
    // registered so the pop lands on the following edge.
    always_comb begin
        prev_ready_d = in_i2s_ready;
        req_d        = in_i2s_ready && !prev_ready_q;
    end

    // Playback FSM, pop control and sample register next-state.
    // NOTE: every output of this block is defaulted first so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        sample_d     = sample_q;
        en_d         = en_q;
        pop          = 1'b0;
        underrun_evt = 1'b0;
        case (state_q)
            S_FILL: begin
                if (level_q >= START_LVL) begin
                    pop     = 1'b1;
                    en_d    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (req_q) begin
                    if (level_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        // Underrun: hand the in-flight request silence and
                        // drop out_en so the transmitter returns to idle.
                        underrun_evt = 1'b1;
                        sample_d     = '0;
                        en_d         = 1'b0;
                        state_d      = S_FILL;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
        if (pop) begin
            sample_d = mem_q[rd_ptr_q];
        end
    end

    // Pointer and level bookkeeping; a simultaneous write and pop keeps the level.
    always_comb begin
        wr_ptr_d = wr_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({wr_fire, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Sticky underrun flag; a new underrun wins over a clear in the same cycle.
    always_comb begin
        underrun_d = underrun_q;
        if (underrun_evt) begin
            underrun_d = 1'b1;
        end else if (in_clr_underrun) begin
            underrun_d = 1'b0;
        end
    end

    // State registers.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q      <= S_FILL;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            sample_q     <= '0;
            en_q         <= 1'b0;
            underrun_q   <= 1'b0;
            prev_ready_q <= 1'b1;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            sample_q     <= sample_d;
            en_q         <= en_d;
            underrun_q   <= underrun_d;
            prev_ready_q <= prev_ready_d;
            req_q        <= req_d;
        end
    end

    assign out_sample   = sample_q;
    assign out_en       = en_q;
    assign out_level    = level_q;
    assign out_underrun = underrun_q;

`ifdef I2S_FIFO_UNDERRUN_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating underrun counter; only reset clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (underrun_evt && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Underrun counter register.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_underrun_cnt = cnt_q;
`else
    assign out_underrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Self-checking bench for i2s_sample_fifo: a queue-based reference model is
// compared against every output on every falling edge, and directed steps
// pin the model with hand-computed literal expectations.

module tb_i2s_sample_fifo;

    localparam int BPS   = 24;
    localparam int DEPTH = 16;
    localparam int START = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [BPS-1:0]  wr_data = '0;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic            i2s_ready = 1'b1;
    logic [BPS-1:0]  sample;
    logic            en;
    logic [4:0]      level;
    logic            underrun;
    logic            clr_underrun = 1'b0;
    logic [15:0]     underrun_cnt;

    int checks = 0;
    int errors = 0;

    i2s_sample_fifo #(.BPS(BPS), .DEPTH_LOG2(4), .START_LEVEL(START)) dut (
        .in_clk           (clk),
        .in_rst           (rst),
        .in_wr_data       (wr_data),
        .in_wr_valid      (wr_valid),
        .out_wr_ready     (wr_ready),
        .in_i2s_ready     (i2s_ready),
        .out_sample       (sample),
        .out_en           (en),
        .out_level        (level),
        .out_underrun     (underrun),
        .in_clr_underrun  (clr_underrun),
        .out_underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

`ifdef I2S_FIFO_UNDERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [BPS-1:0] m_fifo[$];
    logic [BPS-1:0] m_sample = '0;
    bit             m_en = 1'b0;
    bit             m_playing = 1'b0;
    bit             m_flag = 1'b0;
    int             m_cnt = 0;
    bit             m_prev_ready = 1'b1;
    bit             m_pending = 1'b0;

    task automatic model_reset();
        m_fifo.delete();
        m_sample     = '0;
        m_en         = 1'b0;
        m_playing    = 1'b0;
        m_flag       = 1'b0;
        m_cnt        = 0;
        m_prev_ready = 1'b1;
        m_pending    = 1'b0;
    endtask

    // One clock edge of behaviour, evaluated on the inputs seen before the edge.
    task automatic model_step();
        bit accept;
        bit hit_underrun;
        accept       = wr_valid && (m_fifo.size() < DEPTH);
        hit_underrun = 1'b0;
        if (!m_playing) begin
            if (m_fifo.size() >= START) begin
                m_sample  = m_fifo.pop_front();
                m_en      = 1'b1;
                m_playing = 1'b1;
            end
        end else if (m_pending) begin
            if (m_fifo.size() > 0) begin
                m_sample = m_fifo.pop_front();
            end else begin
                hit_underrun = 1'b1;
                m_sample     = '0;
                m_en         = 1'b0;
                m_playing    = 1'b0;
            end
        end
        if (clr_underrun) m_flag = 1'b0;
        if (hit_underrun) begin
            m_flag = 1'b1;
            if (CNT_EN && m_cnt < 16'hFFFF) m_cnt++;
        end
        if (accept) m_fifo.push_back(wr_data);
        m_pending    = i2s_ready && !m_prev_ready;
        m_prev_ready = i2s_ready;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Compare process: every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_sample",   32'(sample),       32'(m_sample));
            check("cmp_en",       32'(en),           32'(m_en));
            check("cmp_level",    32'(level),        32'(m_fifo.size()));
            check("cmp_wr_ready", 32'(wr_ready),     32'(m_fifo.size() != DEPTH));
            check("cmp_underrun", 32'(underrun),     32'(m_flag));
            check("cmp_cnt",      32'(underrun_cnt), 32'(m_cnt));
        end
    end

    // ---------------- stimulus helpers (called just after a falling edge) ----------------
    task automatic wr(input logic [BPS-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic request();
        i2s_ready = 1'b1;
        @(negedge clk);
        i2s_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_sample",   32'(sample),       32'h0);
        check("rst_en",       32'(en),           32'h0);
        check("rst_level",    32'(level),        32'h0);
        check("rst_wr_ready", 32'(wr_ready),     32'h1);
        check("rst_underrun", 32'(underrun),     32'h0);
        check("rst_cnt",      32'(underrun_cnt), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Prefill with ready held idle-high: start one cycle after level hits 4.
        for (int i = 1; i <= 4; i++) wr(BPS'(i));
        check("prefill_level4", 32'(level), 32'd4);
        check("prefill_en_not_yet", 32'(en), 32'h0);
        @(negedge clk);
        check("start_en",     32'(en),     32'h1);
        check("start_sample", 32'(sample), 32'h000001);
        check("start_level",  32'(level),  32'd3);
        repeat (3) @(negedge clk);
        check("idle_high_no_pop", 32'(level), 32'd3);

        // Held-high request pops exactly once, on the second edge after the rise.
        i2s_ready = 1'b0;
        @(negedge clk);
        i2s_ready = 1'b1;
        @(negedge clk);
        check("req_first_edge_sample", 32'(sample), 32'h000001);
        @(negedge clk);
        check("req_sample", 32'(sample), 32'h000002);
        check("req_level",  32'(level),  32'd2);
        repeat (8) @(negedge clk);
        check("req_hold_sample", 32'(sample), 32'h000002);
        check("req_hold_level",  32'(level),  32'd2);
        i2s_ready = 1'b0;
        @(negedge clk);

        // Concurrent write and pop at level 5.
        for (int i = 5; i <= 7; i++) wr(BPS'(i));
        check("conc_pre_level", 32'(level), 32'd5);
        i2s_ready = 1'b1;
        @(negedge clk);
        i2s_ready = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = 24'h000008;
        @(negedge clk);
        wr_valid  = 1'b0;
        check("conc_level",  32'(level),  32'd5);
        check("conc_sample", 32'(sample), 32'h000003);

        // Fill to 16, drop a 17th write, then pop the oldest.
        for (int i = 9; i <= 19; i++) wr(BPS'(i));
        check("full_level", 32'(level),    32'd16);
        check("full_ready", 32'(wr_ready), 32'h0);
        wr(24'hBADBAD);
        check("full_drop_level", 32'(level), 32'd16);
        request();
        check("full_pop_sample", 32'(sample),   32'h000004);
        check("full_pop_level",  32'(level),    32'd15);
        check("full_pop_ready",  32'(wr_ready), 32'h1);

        // Drain to level 7, then reset asynchronously mid-RUN.
        repeat (8) request();
        check("drain_level",  32'(level),  32'd7);
        check("drain_sample", 32'(sample), 32'h00000C);
        #2 rst = 1'b1;
        #1;
        check("arst_sample",   32'(sample),   32'h0);
        check("arst_en",       32'(en),       32'h0);
        check("arst_level",    32'(level),    32'h0);
        check("arst_wr_ready", 32'(wr_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fresh prefill shows stored words were discarded.
        for (int i = 0; i < 4; i++) wr(24'h000100 + BPS'(i));
        @(negedge clk);
        check("refill_sample", 32'(sample), 32'h000100);
        repeat (3) request();
        check("empty_level",  32'(level),  32'd0);
        check("empty_sample", 32'(sample), 32'h000103);

        // Underrun request with a write in the same cycle.
        i2s_ready = 1'b1;
        @(negedge clk);
        i2s_ready = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = 24'h000200;
        @(negedge clk);
        wr_valid  = 1'b0;
        check("ur_sample", 32'(sample),       32'h0);
        check("ur_en",     32'(en),           32'h0);
        check("ur_flag",   32'(underrun),     32'h1);
        check("ur_cnt",    32'(underrun_cnt), CNT_EN ? 32'd1 : 32'd0);
        check("ur_level",  32'(level),        32'd1);

        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        check("clr_flag", 32'(underrun),     32'h0);
        check("clr_cnt",  32'(underrun_cnt), CNT_EN ? 32'd1 : 32'd0);

        // Recovery: refill reasserts out_en with the word written at the underrun.
        for (int i = 1; i <= 3; i++) wr(24'h000200 + BPS'(i));
        @(negedge clk);
        check("recover_en",     32'(en),     32'h1);
        check("recover_sample", 32'(sample), 32'h000200);
        check("recover_level",  32'(level),  32'd3);

        // Second underrun with a clear in the same cycle: set wins.
        repeat (3) request();
        i2s_ready = 1'b1;
        @(negedge clk);
        i2s_ready    = 1'b0;
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        check("setwins_flag", 32'(underrun),     32'h1);
        check("setwins_cnt",  32'(underrun_cnt), CNT_EN ? 32'd2 : 32'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
